instruction_fetch_stage: RTL and testbench
==========================================

# instruction_fetch_stage

Fetch stage of the RISC-V pipeline, sitting directly downstream of the instruction cache. It owns the program counter, presents it to the cache, waits out cache busywait, and captures each returned instruction into the IF/ID pipeline register. It also absorbs branch redirects that arrive mid-miss, so the cache address never changes while a refill is in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction word placed in IF/ID on a bubble (addi x0,x0,0)

Ports. One clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- icache_address  out  32  current PC, driven combinationally from the PC register
- icache_instruction  in  32  instruction for icache_address; valid when icache_busywait=0
- icache_busywait  in  1  cache not ready. Contract: high in every cycle where icache_instruction does not correspond to icache_address.
- branch_taken  in  1  redirect request from EX
- branch_target  in  32  redirect PC; bits [1:0] forced to 0
- stall  in  1  hazard-unit hold of PC and IF/ID
- if_id_pc  out  32  PC of captured instruction
- if_id_pc4  out  32  captured PC+4
- if_id_instruction  out  32  captured instruction, or NOP_INSTR
- if_id_valid  out  1  captured entry is a real instruction
- fetch_count  out  32  valid IF/ID loads since reset
- busy_cycles  out  32  cycles with icache_busywait=1 since reset

## Operation
- Reset: pc=RESET_PC, state=RUN, if_id_pc=0, if_id_pc4=0, if_id_instruction=NOP_INSTR, if_id_valid=0, both counters=0, redirect_pc=0.
- States:
  - RUN: normal fetch.
  - WAIT_REDIRECT: a redirect arrived during busywait and is held in redirect_pc.
- RUN, one row per cycle, first match wins:
  - branch_taken & !icache_busywait: pc <= branch_target; IF/ID <= bubble.
  - branch_taken & icache_busywait: redirect_pc <= branch_target; state <= WAIT_REDIRECT; pc held; IF/ID <= bubble.
  - stall: pc and IF/ID hold (all four fields).
  - icache_busywait: pc held; IF/ID <= bubble.
  - otherwise: IF/ID <= {pc, pc+4, icache_instruction, 1}; pc <= pc+4.
- WAIT_REDIRECT:
  - IF/ID <= bubble every cycle; stall ignored.
  - If branch_taken, the newest target wins: redirect_pc <= branch_target.
  - When icache_busywait=0: pc <= (branch_taken ? branch_target : redirect_pc); the returned instruction is discarded; state <= RUN.
- Bubble = {pc 0, pc4 0, NOP_INSTR, valid 0}.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Counters: 32-bit, wrapping. fetch_count increments on every valid IF/ID load. busy_cycles increments in every non-reset cycle with icache_busywait=1.

## Timing
- Hit: instruction at pc is in IF/ID after the next rising edge; sustained 1 instruction/cycle.
- Miss of N busywait cycles: N bubbles, then capture on the first cycle with busywait=0.
- Redirect with no miss pending: the target is fetched in the cycle after branch_taken; one bubble.
- Redirect during a miss: icache_address stays constant until busywait falls; the target appears on icache_address the cycle after that.
- Reset mid-miss: pc=RESET_PC next cycle; any pending redirect is dropped.
- All outputs except icache_address are registered.

## Structure
- Shared package (cpu_pkg):
  - NOP_INSTR constant.
  - fetch_state_t enum {RUN, WAIT_REDIRECT}.
  - if_id_t struct {pc, pc4, instruction, valid}.
- Sub-module if_id_register: holds if_id_t with load, bubble and hold controls, and reset to bubble. The top level holds the PC, the FSM and the counters.

## Test plan
- Reset, RESET_PC=0, always-hit cache model -> icache_address 0,4,8,12 on consecutive cycles; IF/ID shows pc 0 then 4; if_id_valid=1 from cycle 2; fetch_count=3 after 4 cycles.
- Miss at pc=0x10 with busywait high 5 cycles -> pc held at 0x10; 5 bubbles; busy_cycles=5; instruction for 0x10 captured on cycle 6.
- branch_taken, target 0x41, during cycle 2 of that miss -> address stays 0x10 through the miss; instruction for 0x10 never valid in IF/ID; next address 0x40.
- Two redirects, 0x100 then 0x200, during one miss -> resume at 0x200 only.
- stall=1 for 3 cycles while IF/ID holds pc 0x8 -> IF/ID and pc unchanged; fetch_count unchanged; resume at 0xC.
- pc=32'hFFFF_FFFC, hit -> if_id_pc4=0; next address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID pipeline register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cpu_pkg;

    // PC loaded on reset.
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // addi x0, x0, 0 : the instruction word placed in IF/ID on a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch FSM states.
    typedef enum logic {
        RUN           = 1'b0,  // normal fetch
        WAIT_REDIRECT = 1'b1   // redirect arrived mid-miss, parked in redirect_pc
    } fetch_state_t;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instruction;
        logic        valid;
    } if_id_t;

    // Canonical bubble entry: nothing real flows downstream.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc          = 32'h0000_0000;
        b.pc4         = 32'h0000_0000;
        b.instruction = NOP_INSTR;
        b.valid       = 1'b0;
        return b;
    endfunction

    // Word-align a redirect target; the two low bits are never honoured.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage : cpu_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load, bubble and hold controls; resets to a bubble.
// Latency: 1 cycle from load/bubble request to visible contents.
// Backpressure: holds contents whenever neither load nor bubble is asserted.
module if_id_register
    import cpu_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load_i,
    input  logic   bubble_i,
    input  if_id_t entry_i,
    output if_id_t entry_o
);

    if_id_t entry_q;
    if_id_t entry_d;

    // Next contents: bubble wins over load, otherwise hold.
    always_comb begin
        entry_d = entry_q;
        if (bubble_i) begin
            entry_d = if_id_bubble();
        end else if (load_i) begin
            entry_d = entry_i;
        end
    end

    // Register the entry; synchronous reset lands on a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry_q <= if_id_bubble();
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule : if_id_register

// File: rtl/instruction_fetch_stage.sv
// RISC-V fetch stage: owns the PC, waits out icache busywait, fills IF/ID, parks mid-miss redirects.
// Latency: hit instruction appears in IF/ID one edge after its address is presented; 1 instr/cycle.
// Backpressure: stall holds PC and IF/ID in RUN; busywait holds PC and inserts bubbles.
module instruction_fetch_stage
    import cpu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_instruction,
    input  logic        icache_busywait,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] busy_cycles
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic [31:0]  busy_cycles_q, busy_cycles_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;
    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_in;
    if_id_t       ifid_out;

    // Sequential 32-bit add wraps naturally: FFFF_FFFC + 4 = 0.
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = align_word(branch_target);

    // The cache always sees the architectural PC; during a miss it stays put.
    assign icache_address = pc_q;

    // Candidate IF/ID contents for a normal hit.
    always_comb begin
        ifid_in             = if_id_bubble();
        ifid_in.pc          = pc_q;
        ifid_in.pc4         = pc_plus4;
        ifid_in.instruction = icache_instruction;
        ifid_in.valid       = 1'b1;
    end

    // Next-state, PC and IF/ID control; first matching row wins in RUN.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        ifid_load     = 1'b0;
        ifid_bubble   = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branch_taken && !icache_busywait) begin
                    // Cache is idle, so the address may move immediately.
                    pc_d        = target_aligned;
                    ifid_bubble = 1'b1;
                end else if (branch_taken && icache_busywait) begin
                    // Refill in flight against pc_q: park the target instead.
                    redirect_pc_d = target_aligned;
                    state_d       = WAIT_REDIRECT;
                    ifid_bubble   = 1'b1;
                end else if (stall) begin
                    // Hazard unit holds everything; defaults already hold.
                    ifid_bubble = 1'b0;
                end else if (icache_busywait) begin
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end
            end

            WAIT_REDIRECT: begin
                // The word coming back belongs to the abandoned path, so
                // every cycle here is a bubble and stall has no effect.
                ifid_bubble = 1'b1;
                if (branch_taken) begin
                    redirect_pc_d = target_aligned;
                end
                if (!icache_busywait) begin
                    pc_d    = branch_taken ? target_aligned : redirect_pc_q;
                    state_d = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Performance counters: valid IF/ID loads and busywait cycles.
    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, ifid_load};
        busy_cycles_d = busy_cycles_q + {31'd0, icache_busywait};
    end

    // PC, FSM, parked redirect and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'h0000_0000;
            fetch_count_q <= 32'h0000_0000;
            busy_cycles_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            fetch_count_q <= fetch_count_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    if_id_register u_if_id (
        .clock    (clock),
        .reset    (reset),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .entry_i  (ifid_in),
        .entry_o  (ifid_out)
    );

    assign if_id_pc          = ifid_out.pc;
    assign if_id_pc4         = ifid_out.pc4;
    assign if_id_instruction = ifid_out.instruction;
    assign if_id_valid       = ifid_out.valid;
    assign fetch_count       = fetch_count_q;
    assign busy_cycles       = busy_cycles_q;

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: vector table plus a reset-mid-miss sequence.
// Latency: checks address before each edge and registered outputs 1 time unit after it.
// Backpressure: busywait and stall are driven directly from the vectors.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] icache_address;
    logic [31:0] icache_instruction;
    logic        icache_busywait;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] busy_cycles;

    int n_cmp;
    int n_bad;

    instruction_fetch_stage dut (
        .clock              (clock),
        .reset              (reset),
        .icache_address     (icache_address),
        .icache_instruction (icache_instruction),
        .icache_busywait    (icache_busywait),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .stall              (stall),
        .if_id_pc           (if_id_pc),
        .if_id_pc4          (if_id_pc4),
        .if_id_instruction  (if_id_instruction),
        .if_id_valid        (if_id_valid),
        .fetch_count        (fetch_count),
        .busy_cycles        (busy_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache model: the word at address A is ~A; garbage while busy.
    function automatic logic [31:0] iw(input logic [31:0] a);
        return ~a;
    endfunction
    assign icache_instruction = icache_busywait ? 32'hDEAD_BEEF : iw(icache_address);

    typedef struct {
        logic        bt;
        logic [31:0] tgt;
        logic        stl;
        logic        bw;
        logic [31:0] addr;   // icache_address expected before the edge
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] fc;
        logic [31:0] bc;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic bt, input logic [31:0] tgt, input logic stl,
                                input logic bw, input logic [31:0] addr,
                                input logic [31:0] pc, input logic [31:0] pc4,
                                input logic [31:0] instr, input logic valid,
                                input logic [31:0] fc, input logic [31:0] bc);
        vec_t v;
        v.bt = bt; v.tgt = tgt; v.stl = stl; v.bw = bw; v.addr = addr;
        v.pc = pc; v.pc4 = pc4; v.instr = instr; v.valid = valid; v.fc = fc; v.bc = bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] instr, input logic valid,
                            input logic [31:0] fc, input logic [31:0] bc);
        chk({tag, ".if_id_pc"}, if_id_pc, pc);
        chk({tag, ".if_id_pc4"}, if_id_pc4, pc4);
        chk({tag, ".if_id_instruction"}, if_id_instruction, instr);
        chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
        chk({tag, ".fetch_count"}, fetch_count, fc);
        chk({tag, ".busy_cycles"}, busy_cycles, bc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //            bt  tgt            stl   bw    addr           pc             pc4            instr               v     fc  bc
        // Sustained hits from reset.
        vecs[0]  = mk(0, 32'h0,          0,    0,    32'h0,         32'h0,         32'h4,         iw(32'h0),          1,    1,  0);
        vecs[1]  = mk(0, 32'h0,          0,    0,    32'h4,         32'h4,         32'h8,         iw(32'h4),          1,    2,  0);
        vecs[2]  = mk(0, 32'h0,          0,    0,    32'h8,         32'h8,         32'hC,         iw(32'h8),          1,    3,  0);
        vecs[3]  = mk(0, 32'h0,          0,    0,    32'hC,         32'hC,         32'h10,        iw(32'hC),          1,    4,  0);
        // Five-cycle miss at 0x10, then capture.
        vecs[4]  = mk(0, 32'h0,          0,    1,    32'h10,        32'h0,         32'h0,         NOP,                0,    4,  1);
        vecs[5]  = mk(0, 32'h0,          0,    1,    32'h10,        32'h0,         32'h0,         NOP,                0,    4,  2);
        vecs[6]  = mk(0, 32'h0,          0,    1,    32'h10,        32'h0,         32'h0,         NOP,                0,    4,  3);
        vecs[7]  = mk(0, 32'h0,          0,    1,    32'h10,        32'h0,         32'h0,         NOP,                0,    4,  4);
        vecs[8]  = mk(0, 32'h0,          0,    1,    32'h10,        32'h0,         32'h0,         NOP,                0,    4,  5);
        vecs[9]  = mk(0, 32'h0,          0,    0,    32'h10,        32'h10,        32'h14,        iw(32'h10),         1,    5,  5);
        vecs[10] = mk(0, 32'h0,          0,    0,    32'h14,        32'h14,        32'h18,        iw(32'h14),         1,    6,  5);
        // Redirect to 0x41 in the second cycle of a miss at 0x18.
        vecs[11] = mk(0, 32'h0,          0,    1,    32'h18,        32'h0,         32'h0,         NOP,                0,    6,  6);
        vecs[12] = mk(1, 32'h41,         0,    1,    32'h18,        32'h0,         32'h0,         NOP,                0,    6,  7);
        vecs[13] = mk(0, 32'h0,          0,    1,    32'h18,        32'h0,         32'h0,         NOP,                0,    6,  8);
        vecs[14] = mk(0, 32'h0,          0,    0,    32'h18,        32'h0,         32'h0,         NOP,                0,    6,  8);
        vecs[15] = mk(0, 32'h0,          0,    0,    32'h40,        32'h40,        32'h44,        iw(32'h40),         1,    7,  8);
        // Two redirects in one miss: newest (0x200) wins.
        vecs[16] = mk(1, 32'h100,        0,    1,    32'h44,        32'h0,         32'h0,         NOP,                0,    7,  9);
        vecs[17] = mk(1, 32'h200,        0,    1,    32'h44,        32'h0,         32'h0,         NOP,                0,    7,  10);
        vecs[18] = mk(0, 32'h0,          0,    1,    32'h44,        32'h0,         32'h0,         NOP,                0,    7,  11);
        vecs[19] = mk(0, 32'h0,          0,    0,    32'h44,        32'h0,         32'h0,         NOP,                0,    7,  11);
        vecs[20] = mk(0, 32'h0,          0,    0,    32'h200,       32'h200,       32'h204,       iw(32'h200),        1,    8,  11);
        // Three-cycle stall holds IF/ID and PC.
        vecs[21] = mk(0, 32'h0,          1,    0,    32'h204,       32'h200,       32'h204,       iw(32'h200),        1,    8,  11);
        vecs[22] = mk(0, 32'h0,          1,    0,    32'h204,       32'h200,       32'h204,       iw(32'h200),        1,    8,  11);
        vecs[23] = mk(0, 32'h0,          1,    0,    32'h204,       32'h200,       32'h204,       iw(32'h200),        1,    8,  11);
        vecs[24] = mk(0, 32'h0,          0,    0,    32'h204,       32'h204,       32'h208,       iw(32'h204),        1,    9,  11);
        // Redirect with no miss to the top word, then wrap to 0.
        vecs[25] = mk(1, 32'hFFFF_FFFC,  0,    0,    32'h208,       32'h0,         32'h0,         NOP,                0,    9,  11);
        vecs[26] = mk(0, 32'h0,          0,    0,    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         iw(32'hFFFF_FFFC),  1,    10, 11);
        vecs[27] = mk(0, 32'h0,          0,    0,    32'h0,         32'h0,         32'h4,         iw(32'h0),          1,    11, 11);
        // Stall outranks busywait in RUN; busy cycle still counted.
        vecs[28] = mk(0, 32'h0,          1,    1,    32'h4,         32'h0,         32'h4,         iw(32'h0),          1,    11, 12);
        // Parked redirect overridden by a branch on the resolving cycle; stall ignored.
        vecs[29] = mk(1, 32'h300,        0,    1,    32'h4,         32'h0,         32'h0,         NOP,                0,    11, 13);
        vecs[30] = mk(1, 32'h404,        1,    0,    32'h4,         32'h0,         32'h0,         NOP,                0,    11, 13);
        vecs[31] = mk(0, 32'h0,          0,    0,    32'h404,       32'h404,       32'h408,       iw(32'h404),        1,    12, 13);

        // Reset.
        reset           = 1'b1;
        branch_taken    = 1'b0;
        branch_target   = 32'h0;
        stall           = 1'b0;
        icache_busywait = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset.icache_address", icache_address, 32'h0);
        chk_regs("reset", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            branch_taken    = vecs[i].bt;
            branch_target   = vecs[i].tgt;
            stall           = vecs[i].stl;
            icache_busywait = vecs[i].bw;
            #1;
            chk($sformatf("v%0d.icache_address", i), icache_address, vecs[i].addr);
            @(posedge clock);
            #1;
            chk_regs($sformatf("v%0d", i), vecs[i].pc, vecs[i].pc4, vecs[i].instr,
                     vecs[i].valid, vecs[i].fc, vecs[i].bc);
        end

        // Reset mid-miss with a parked redirect: redirect must be dropped.
        branch_taken    = 1'b1;
        branch_target   = 32'h500;
        stall           = 1'b0;
        icache_busywait = 1'b1;
        @(posedge clock);
        #1;
        branch_taken = 1'b0;
        reset        = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_mid.icache_address", icache_address, 32'h0);
        chk_regs("rst_mid", 32'h0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
        reset           = 1'b0;
        icache_busywait = 1'b0;
        #1;
        chk("rst_mid.resume_address", icache_address, 32'h0);
        @(posedge clock);
        #1;
        chk_regs("rst_mid.resume", 32'h0, 32'h4, iw(32'h0), 1'b1, 32'h1, 32'h0);
        chk("rst_mid.next_address", icache_address, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_instruction_fetch_stage
